// File: rtl/mux_2.sv
// mux_2: two-input data mux with a combinational output, an enabled
// registered copy, and sel-change tracking (pulse + saturating counter).
module mux_2 #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sel,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 en,
    output logic [WIDTH-1:0]     f,
    output logic [WIDTH-1:0]     f_q,
    output logic                 sel_q,
    output logic                 sel_chg,
    output logic [CNT_WIDTH-1:0] toggle_cnt
);

    logic [WIDTH-1:0]     w_f;
    logic                 w_sel_diff;
    logic                 w_cnt_sat;

    logic [WIDTH-1:0]     r_f_q;
    logic                 r_sel_q;
    logic                 r_sel_chg;
    logic [CNT_WIDTH-1:0] r_toggle_cnt;

    // Data select; an unknown sel poisons the whole output in simulation
    // while the default arm keeps synthesis latch-free.
    always_comb begin
        w_f = '0;
        case (sel)
            1'b0:    w_f = a;
            1'b1:    w_f = b;
            default: w_f = 'x;
        endcase
    end

    // A change is judged against the last sampled sel; after reset that is 0.
    assign w_sel_diff = (sel != r_sel_q);
    assign w_cnt_sat  = &r_toggle_cnt;

    // Registered output stage, loaded only on enabled edges.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_f_q <= '0;
        else if (en)
            r_f_q <= w_f;
    end

    // Sampled sel and its one-cycle change pulse, both independent of en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel_q   <= 1'b0;
            r_sel_chg <= 1'b0;
        end else begin
            r_sel_q   <= sel;
            r_sel_chg <= w_sel_diff;
        end
    end

    // Count sel changes, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_toggle_cnt <= '0;
        else if (w_sel_diff && !w_cnt_sat)
            r_toggle_cnt <= r_toggle_cnt + CNT_WIDTH'(1);
    end

    assign f          = w_f;
    assign f_q        = r_f_q;
    assign sel_q      = r_sel_q;
    assign sel_chg    = r_sel_chg;
    assign toggle_cnt = r_toggle_cnt;

endmodule

// File: tb/tb_mux_2.sv
// tb_mux_2: scoreboard bench. The driver pushes the expected post-edge
// outputs for every cycle; the monitor pops and compares after each edge.
module tb_mux_2;

    logic        clk = 1'b0;
    logic        rst_n, sel, en;
    logic [31:0] a, b;
    logic [31:0] f, f_q, f2, f_q2;
    logic        sel_q, sel_chg, sel_q2, sel_chg2;
    logic [15:0] toggle_cnt;
    logic [1:0]  toggle_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    mux_2 #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .a(a), .b(b), .en(en),
        .f(f), .f_q(f_q), .sel_q(sel_q), .sel_chg(sel_chg),
        .toggle_cnt(toggle_cnt)
    );

    mux_2 #(.WIDTH(32), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sel(sel), .a(a), .b(b), .en(en),
        .f(f2), .f_q(f_q2), .sel_q(sel_q2), .sel_chg(sel_chg2),
        .toggle_cnt(toggle_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f;
        logic [31:0] fq;
        logic        selq;
        logic        chg;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t sb[$];

    // Reference model: the output register, the last sampled sel and the
    // number of sel changes since reset as a plain integer.
    logic [31:0] m_fq   = '0;
    logic        m_prev = 1'b0;
    int          m_changes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and record what the
    // outputs must look like right after the following rising edge.
    task automatic step(input logic r, input logic s, input logic e,
                        input logic [31:0] av, input logic [31:0] bv);
        exp_t x;
        logic chg;
        @(negedge clk);
        rst_n = r; sel = s; en = e; a = av; b = bv;
        x.f = s ? bv : av;
        if (!r) begin
            m_fq = '0; m_prev = 1'b0; m_changes = 0; chg = 1'b0;
        end else begin
            chg = (s != m_prev);
            if (chg) m_changes++;
            if (e) m_fq = x.f;
            m_prev = s;
        end
        x.fq   = m_fq;
        x.selq = m_prev;
        x.chg  = chg;
        x.cnt  = (m_changes > 65535) ? 16'hFFFF : 16'(m_changes);
        x.cnt2 = (m_changes > 3) ? 2'd3 : 2'(m_changes);
        sb.push_back(x);
    endtask

    // Monitor: every rising edge presents a new set of registered outputs.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("f",            f,                   x.f);
                chk("f_q",          f_q,                 x.fq);
                chk("sel_q",        {31'd0, sel_q},      {31'd0, x.selq});
                chk("sel_chg",      {31'd0, sel_chg},    {31'd0, x.chg});
                chk("toggle_cnt",   {16'd0, toggle_cnt}, {16'd0, x.cnt});
                chk("toggle_cnt_w2",{30'd0, toggle_cnt2},{30'd0, x.cnt2});
                chk("f_q_w2",       f_q2,                x.fq);
            end
        end
    end

    initial begin
        int wait_cyc;
        rst_n = 1'b0; sel = 1'b0; en = 1'b0; a = '0; b = '0;

        // Reset with arbitrary inputs; en is high to show reset wins.
        step(0, 1, 1, $urandom, $urandom);
        step(0, 0, 1, $urandom, $urandom);

        // Zero-latency mux, checked between edges.
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0; a = 32'h1234_5678; b = 32'h9ABC_DEF0; sel = 1'b0;
        #1 chk("f_sel0_comb", f, 32'h1234_5678);
        sel = 1'b1;
        #1 chk("f_sel1_comb", f, 32'h9ABC_DEF0);
        sel = 1'b0;
        #1 chk("f_back_to_a", f, 32'h1234_5678);

        // Load then hold of the output register.
        step(0, 0, 0, 32'h0, 32'h0);
        step(1, 1, 1, 32'h1111_1111, 32'hDEAD_BEEF);
        step(1, 1, 0, 32'h0, 32'h0);
        step(1, 1, 0, 32'h5555_5555, 32'h0);

        // sel 0,1,1,0 after reset: pulses 0,1,0,1 and count ends at 2.
        step(0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h0, 32'h0);
        step(1, 1, 0, 32'h0, 32'h0);
        step(1, 1, 0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h0, 32'h0);

        // Five consecutive toggles: narrow counter reads 1,2,3,3,3.
        step(0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++)
            step(1, (i % 2 == 0), 1, 32'hA5A5_0000 | i, 32'h5A5A_0000 | i);

        // Reset together with en while f_q is nonzero and count is saturated.
        step(0, 1, 1, 32'hCAFE_0001, 32'hBEEF_0002);
        step(0, 0, 1, 32'hCAFE_0003, 32'hBEEF_0004);

        // Randomized traffic with occasional reset and data-only changes.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 24) != 0), (($urandom_range(0, 3) == 0) ? ~sel : sel),
                 $urandom_range(0, 1), $urandom, $urandom);

        // Drain the scoreboard with a bounded wait.
        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_2.md
MUX_2 -- requirements
Module: mux_2

Interface
REQ-001 Parameter WIDTH, default 32: data path width in bits; legal range 1..256.
REQ-002 Parameter CNT_WIDTH, default 16: width of the select-toggle counter; legal range 1..32.
REQ-003 Port clk  input  1: single clock; all sequential state updates on its rising edge.
REQ-004 Port rst_n  input  1: reset; synchronous, active-low.
REQ-005 Port sel  input  1: select; 0 chooses a, 1 chooses b.
REQ-006 Port a  input  WIDTH: data input chosen when sel=0.
REQ-007 Port b  input  WIDTH: data input chosen when sel=1.
REQ-008 Port en  input  1: load enable for the registered output stage.
REQ-009 Port f  output  WIDTH: combinational mux output.
REQ-010 Port f_q  output  WIDTH: registered mux output.
REQ-011 Port sel_q  output  1: registered copy of sel.
REQ-012 Port sel_chg  output  1: one-cycle pulse indicating that sel differs from the previously sampled sel.
REQ-013 Port toggle_cnt  output  CNT_WIDTH: saturating count of sel changes since reset.

Function
REQ-014 f SHALL equal a when sel=0 and b when sel=1, purely combinationally, with zero-cycle latency and no dependence on clk, rst_n or en.
REQ-015 If sel is X/Z in simulation, f SHALL be driven all-X; in synthesis, no latch SHALL be inferred.
REQ-016 On a rising clk edge with rst_n=1 and en=1, f_q SHALL load the value of f; with en=0, f_q SHALL hold its value.
REQ-017 sel_q SHALL load sel on every rising clk edge with rst_n=1, independent of en.
REQ-018 sel_chg SHALL be registered, going to 1 on the edge where sel differs from sel_q and to 0 otherwise; it SHALL be high for exactly one cycle per change.
REQ-019 toggle_cnt SHALL increment by 1 on each edge where sel differs from sel_q and SHALL saturate at all-ones without wrapping.
REQ-020 Simultaneous events: en=1 together with a sel change SHALL load f_q from the new f (the current sel), update sel_q, pulse sel_chg and increment toggle_cnt in the same edge.
REQ-021 Changes of a or b while sel is steady SHALL propagate to f immediately and to f_q only on an enabled edge; they SHALL NOT affect sel_chg or toggle_cnt.
REQ-022 The block SHALL contain no state machine other than the registers listed; f_q, sel_q, sel_chg and toggle_cnt are its only state.

Reset
REQ-023 When rst_n=0 at a rising clk edge, f_q SHALL become 0, sel_q SHALL become 0, sel_chg SHALL become 0 and toggle_cnt SHALL become 0; reset takes priority over en.
REQ-024 Reset SHALL NOT affect f, which continues to follow sel, a and b during reset.
REQ-025 Reset asserted in the middle of operation SHALL clear state on the next edge, discarding any pending toggle; the first edge after release compares sel against sel_q=0.
REQ-026 Before the first reset edge, register contents are unspecified; benches SHALL apply reset for at least 1 cycle.

Verification
REQ-027 With WIDTH=32, a=0x1234_5678, b=0x9ABC_DEF0: sel=0 -> f=0x1234_5678; sel=1 -> f=0x9ABC_DEF0, with no clock edge required.
REQ-028 With en=1, sel=1, b=0xDEAD_BEEF for one edge -> f_q=0xDEAD_BEEF; then en=0 and b=0 -> f_q remains 0xDEAD_BEEF while f=0.
REQ-029 After reset, drive sel 0->1->1->0 over 4 edges -> sel_chg sequence 0,1,0,1 and toggle_cnt final value 2.
REQ-030 With CNT_WIDTH=2, toggle sel on 5 consecutive edges -> toggle_cnt reads 1,2,3,3,3 (saturated).
REQ-031 With toggle_cnt=3 and f_q nonzero, assert rst_n=0 together with en=1 for one edge -> f_q=0, sel_q=0, sel_chg=0, toggle_cnt=0, while f still tracks the inputs.
